// File: rtl/imem_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_dmem_arbiter
//
// Shares one single-port synchronous memory between the instruction-fetch
// requester (if_*) and the load/store requester (d_*). One access is in flight
// at a time: IDLE samples the requests and latches the winner, ACCESS drives
// the memory port for one cycle with a grant pulse, and WAIT covers the memory
// latency before read data is returned with a one-cycle valid pulse.
// Data accesses win ties unless fetch has been passed over STARVE_MAX times.
//
// Ports:
//   clock, reset              clock, asynchronous active-low reset
//   if_req/if_addr            fetch request (level) and address
//   if_gnt/if_rvalid/if_rdata fetch grant pulse, read-valid pulse, read data
//   d_req/d_we/d_addr/d_wdata data request (level), write enable, addr, data
//   d_gnt/d_rvalid/d_rdata    data grant pulse, read-valid pulse, read data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  shared memory port
//   busy                      high whenever an access is in flight
// All outputs are registered.
// -----------------------------------------------------------------------------
module imem_dmem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,   // legal range 1..4
    parameter int STARVE_MAX = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int             SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]  STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [2:0]     LAT_INIT   = 3'(MEM_LAT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT
    } state_e;

    state_e            state_q,     state_d;
    logic [2:0]        lat_q,       lat_d;
    logic [SW-1:0]     starve_q,    starve_d;
    logic              sel_d_q,     sel_d_d;     // 1: D port owns the access
    logic              we_q,        we_d;
    logic              if_gnt_q,    if_gnt_d;
    logic              d_gnt_q,     d_gnt_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              d_rvalid_q,  d_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              busy_q,      busy_d;
    logic              d_wins;

    // Outputs are registered, so the next-state logic also computes the
    // output values for the state being entered. mem_addr_q/mem_wdata_q double
    // as the latched request address and write data.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        sel_d_d     = sel_d_q;
        we_d        = we_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        // Fetch is forced once it has been passed over STARVE_MAX times.
        d_wins      = d_req && !(if_req && (starve_q == STARVE_TOP));

        unique case (state_q)
            S_IDLE: begin
                if (!if_req) begin
                    starve_d = '0;
                end
                if (if_req || d_req) begin
                    state_d     = S_ACCESS;
                    sel_d_d     = d_wins;
                    we_d        = d_wins && d_we;
                    if_gnt_d    = !d_wins;
                    d_gnt_d     = d_wins;
                    mem_en_d    = 1'b1;
                    mem_we_d    = d_wins && d_we;
                    mem_addr_d  = d_wins ? d_addr  : if_addr;
                    mem_wdata_d = d_wins ? d_wdata : '0;
                    if (!d_wins) begin
                        starve_d = '0;
                    end else if (if_req && (starve_q != STARVE_TOP)) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                state_d = S_WAIT;
                lat_d   = LAT_INIT;
            end
            S_WAIT: begin
                if (lat_q <= 3'd1) begin
                    // Last latency cycle: mem_rdata is valid now.
                    state_d = S_IDLE;
                    lat_d   = '0;
                    if (!we_q) begin
                        if (sel_d_q) begin
                            d_rdata_d  = mem_rdata;
                            d_rvalid_d = 1'b1;
                        end else begin
                            if_rdata_d  = mem_rdata;
                            if_rvalid_d = 1'b1;
                        end
                    end
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            lat_q       <= '0;
            starve_q    <= '0;
            sel_d_q     <= 1'b0;
            we_q        <= 1'b0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            sel_d_q     <= sel_d_d;
            we_q        <= we_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule
